resent_pckt_tx: RTL
===================

Name: resent_pckt_tx

Overview:
- Injection-side packet transmitter for one butterfly input channel.
- Accepts a packet from the local source and serialises it into flits: one header flit, then back-to-back payload flits, then null.
- Drives the flit stream into the output-port allocator's input channel and holds the header until the allocator grants it.
- Retransmits on NACK or ACK timeout with the priority field set, up to a retry limit, then drops the packet and flags it.

Parameters:
- PORTS, 4, number of switch ports; the address field is $clog2(PORTS) = 2 bits.
- MAX_LEN, 8, maximum payload flits per packet.
- LEN_W, $clog2(MAX_LEN+1) = 4, width of the length field.
- TIMEOUT, 64, cycles to wait for ACK/NACK after the last payload flit.
- MAX_RETRY, 3, number of retransmissions before drop.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pkt_valid  in  1  source offers a packet
- pkt_ready  out  1  transmitter idle; packet accepted on pkt_valid & pkt_ready
- pkt_dst  in  2  destination output port
- pkt_len  in  LEN_W  payload flit count, legal range 1..MAX_LEN
- pkt_data  in  4*MAX_LEN  payload nibbles; nibble 0 is sent first
- out_flit  out  8  [7:4] type/address nibble (MSN), [3:0] data nibble (LSN)
- out_priority  out  1  priority field for this channel
- out_gnt  in  1  allocator grant for this channel's header, same cycle
- ack_valid  in  1  response from destination, single-cycle
- ack_nack  in  1  qualifies ack_valid; 1 = NACK, 0 = ACK
- tx_done  out  1  one-cycle pulse when the packet is ACKed
- tx_drop  out  1  one-cycle pulse when the packet is dropped after MAX_RETRY

Behaviour:
- Flit encoding:
  - header = {2'b11, dst, 4'h0}
  - payload = {2'b10, 2'b00, nibble}
  - null = 8'h00
- Reset (async, immediate):
  - state IDLE
  - out_flit = 8'h00, out_priority = 0
  - tx_done = 0, tx_drop = 0
  - retry and timeout counters cleared; buffer contents don't-care
  - Reset mid-packet abandons the packet with no tx_drop pulse.
- All outputs are registered except pkt_ready, which is (state == IDLE).
- FSM states: IDLE, HDR, PAYLOAD, WAIT_ACK.
- IDLE:
  - Drives null.
  - On pkt_valid: latch dst, len and data; retry counter = 0; go to HDR. The header appears on out_flit the next cycle.
- HDR:
  - Drives the header flit; out_priority = (retry counter != 0).
  - If out_gnt = 0: hold the header unchanged. There is no timeout while waiting for a grant.
  - If out_gnt = 1: the next cycle drives payload nibble 0; go to PAYLOAD.
- PAYLOAD:
  - Drives one payload flit per cycle, strictly contiguous with no bubbles. The allocator's hold depends on this.
  - out_gnt is ignored.
  - After nibble len-1, the next cycle drives null; timeout counter = 0; go to WAIT_ACK.
  - out_priority stays as set in HDR.
  - Latency from grant to last payload flit: len cycles.
- WAIT_ACK:
  - Drives null; out_priority = 0.
  - The timeout counter increments each cycle.
  - ACK (ack_valid & ~ack_nack): pulse tx_done; go to IDLE.
  - NACK, or counter reaching TIMEOUT-1:
    - retry < MAX_RETRY: retry++; go to HDR, resending from the latched buffer.
    - retry == MAX_RETRY: pulse tx_drop; go to IDLE.
- Simultaneous events:
  - ACK in the timeout cycle: ACK wins.
  - ack_valid outside WAIT_ACK is ignored (a stale response is never counted).
  - pkt_valid while not IDLE is not accepted.
- pkt_len of 0 or above MAX_LEN is illegal; the bench asserts this and the RTL behaviour is undefined.

Decomposition:
- Shared package sb_pkg holds:
  - HEADER_TYPE = 2'b11, PAYLOAD_TYPE = 2'b10, NULL_TYPE = 2'b00
  - flit_t struct {type, addr, data}
  - state enum tx_state_t
  - the PORTS constant
  - This package is shared with the allocator.
- Single module. The payload buffer is an index into the latched pkt_data, not a sub-module.

Test Plan:
- Basic packet:
  - Stimulus: dst=2, len=3, data nibbles A,B,C; out_gnt tied 1.
  - Required stream: 8'hE0, 8'h8A, 8'h8B, 8'h8C, 8'h00.
  - ACK 5 cycles later gives a tx_done pulse and pkt_ready=1 the next cycle.
- Grant stall:
  - Stimulus: out_gnt=0 for 10 cycles, then 1.
  - Required: header 8'hE0 held for 11 cycles; payload starts the cycle after the grant with no gaps.
- NACK retry:
  - Stimulus: NACK in WAIT_ACK.
  - Required: header resent with out_priority=1 across the header and all payload flits; ACK then gives tx_done.
- Timeout, then drop:
  - Stimulus: no response ever arrives.
  - Required: 4 transmissions total, each separated by 64 null cycles; tx_drop pulses once and the block returns to IDLE.
- ACK/timeout collision:
  - Stimulus: ACK arrives in cycle 63 of WAIT_ACK.
  - Required: tx_done pulses, no retransmission.
  - Stimulus: ack_valid while in PAYLOAD.
  - Required: ignored.
- Reset mid-PAYLOAD:
  - Stimulus: assert rst while in PAYLOAD.
  - Required: out_flit = 8'h00 immediately (asynchronously), no tx_drop, pkt_ready=1 after release.

Source files
------------

// File: rtl/sb_pkg.sv
// sb_pkg: flit format and channel-state types shared by the butterfly
// injection transmitter and the output-port allocator.
package sb_pkg;

  localparam int PORTS  = 4;
  localparam int ADDR_W = $clog2(PORTS);

  localparam logic [1:0] HEADER_TYPE  = 2'b11;
  localparam logic [1:0] PAYLOAD_TYPE = 2'b10;
  localparam logic [1:0] NULL_TYPE    = 2'b00;

  typedef struct packed {
    logic [1:0]        typ;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        data;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HDR      = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_WAIT_ACK = 2'd3
  } tx_state_t;

  localparam flit_t NULL_FLIT = '{
    typ:  NULL_TYPE,
    addr: '0,
    data: 4'h0
  };

  function automatic flit_t mk_hdr(
    input logic [ADDR_W-1:0] dst
  );
    flit_t f;
    f.typ  = HEADER_TYPE;
    f.addr = dst;
    f.data = 4'h0;
    return f;
  endfunction

  function automatic flit_t mk_pay(
    input logic [3:0] nib
  );
    flit_t f;
    f.typ  = PAYLOAD_TYPE;
    f.addr = '0;
    f.data = nib;
    return f;
  endfunction

endpackage

// File: rtl/resent_pckt_tx_if.sv
// resent_pckt_tx_if: packet source, allocator and ack-return signals of one
// butterfly injection channel.
interface resent_pckt_tx_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  import sb_pkg::*;

  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [ADDR_W-1:0]      pkt_dst;
  logic [LEN_W-1:0]       pkt_len;
  logic [4*MAX_LEN-1:0]   pkt_data;
  logic [7:0]             out_flit;
  logic                   out_priority;
  logic                   out_gnt;
  logic                   ack_valid;
  logic                   ack_nack;
  logic                   tx_done;
  logic                   tx_drop;

  modport master (
    output pkt_valid,
    output pkt_dst,
    output pkt_len,
    output pkt_data,
    output out_gnt,
    output ack_valid,
    output ack_nack,
    input  pkt_ready,
    input  out_flit,
    input  out_priority,
    input  tx_done,
    input  tx_drop
  );

  modport slave (
    input  pkt_valid,
    input  pkt_dst,
    input  pkt_len,
    input  pkt_data,
    input  out_gnt,
    input  ack_valid,
    input  ack_nack,
    output pkt_ready,
    output out_flit,
    output out_priority,
    output tx_done,
    output tx_drop
  );

endinterface

// File: rtl/resent_pckt_tx.sv
// resent_pckt_tx: serialises a latched packet into header/payload flits and
// retransmits with priority on NACK or ack timeout, dropping after retries.
module resent_pckt_tx
  import sb_pkg::*;
#(
  parameter int MAX_LEN   = 8,
  parameter int LEN_W     = $clog2(MAX_LEN + 1),
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input logic             clk,
  input logic             rst,
  resent_pckt_tx_if.slave bus
);

  localparam logic [1:0] IDLE     = ST_IDLE;
  localparam logic [1:0] HDR      = ST_HDR;
  localparam logic [1:0] PAYLOAD  = ST_PAYLOAD;
  localparam logic [1:0] WAIT_ACK = ST_WAIT_ACK;

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int DAT_W = 4 * MAX_LEN;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DAT_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [RTY_W-1:0]  rty_q, rty_d;
  flit_t             flit_q, flit_d;
  logic              prio_q, prio_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;

  logic              is_ack;
  logic              is_nack;
  logic              last_nib;
  logic              timed_out;
  logic [IDX_W-1:0]  nib_idx;
  logic [3:0]        nib;

  assign is_ack    = bus.ack_valid & ~bus.ack_nack;
  assign is_nack   = bus.ack_valid &  bus.ack_nack;
  assign last_nib  = LEN_W'(idx_q) == (len_q - LEN_W'(1));
  assign timed_out = tmo_q == TMO_LAST;

  // Nibble shown next cycle: 0 when leaving HDR, else the one after idx_q.
  assign nib_idx = (state_q == HDR) ? '0 : idx_q + IDX_W'(1);
  assign nib     = data_q[{nib_idx, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    rty_d   = rty_q;
    flit_d  = flit_q;
    prio_d  = prio_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        flit_d = NULL_FLIT;
        prio_d = 1'b0;
        if (bus.pkt_valid) begin
          dst_d   = bus.pkt_dst;
          len_d   = bus.pkt_len;
          data_d  = bus.pkt_data;
          rty_d   = '0;
          flit_d  = mk_hdr(bus.pkt_dst);
          state_d = HDR;
        end
      end
      HDR: begin
        if (bus.out_gnt) begin
          idx_d   = '0;
          flit_d  = mk_pay(nib);
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (last_nib) begin
          flit_d  = NULL_FLIT;
          prio_d  = 1'b0;
          tmo_d   = '0;
          state_d = WAIT_ACK;
        end else begin
          idx_d  = nib_idx;
          flit_d = mk_pay(nib);
        end
      end
      WAIT_ACK: begin
        tmo_d = tmo_q + TMO_W'(1);
        // An ACK landing in the timeout cycle still completes the packet.
        if (is_ack) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (is_nack || timed_out) begin
          if (rty_q == RTY_LAST) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rty_d   = rty_q + RTY_W'(1);
            flit_d  = mk_hdr(dst_q);
            prio_d  = 1'b1;
            state_d = HDR;
          end
        end
      end
      default: begin
        flit_d  = NULL_FLIT;
        prio_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      rty_q   <= '0;
      flit_q  <= NULL_FLIT;
      prio_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      rty_q   <= rty_d;
      flit_q  <= flit_d;
      prio_q  <= prio_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.pkt_ready    = state_q == IDLE;
  assign bus.out_flit     = flit_q;
  assign bus.out_priority = prio_q;
  assign bus.tx_done      = done_q;
  assign bus.tx_drop      = drop_q;

endmodule
